// File: rtl/bist_pkg.sv
// bist_pkg
//   Shared definitions for the BIST response-side blocks.
//   - state_t   : checker FSM states (IDLE / RUN / DONE)
//   - POLY_*    : default MISR feedback polynomials per signature width
//   - misr_next : one MISR step on a SIG_MAX-wide container; only the low
//                 w bits are meaningful, the rest are returned as zero.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SIG_MAX = 64;

    localparam logic [7:0]  POLY_8  = 8'hB8;
    localparam logic [15:0] POLY_16 = 16'h8016;
    localparam logic [31:0] POLY_32 = 32'h8020_0003;

    // Shift left, fold the bit that falls off the top back in through the
    // polynomial, then inject the data word. w is the live register width.
    function automatic logic [SIG_MAX-1:0] misr_next(
        input logic [SIG_MAX-1:0] sig,
        input logic [SIG_MAX-1:0] data,
        input logic [SIG_MAX-1:0] poly,
        input int unsigned        w
    );
        logic [SIG_MAX-1:0] mask;
        logic [SIG_MAX-1:0] nxt;
        logic               msb;
        mask = '1;
        mask = mask >> (SIG_MAX - w);
        msb  = |(sig & (64'd1 << (w - 1)));
        nxt  = (sig << 1) ^ (msb ? poly : '0) ^ data;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr
//   Multiple-input signature register. Also used by the pattern-side LFSR
//   checks, so it knows nothing about sessions beyond clear/enable.
//   Ports:
//     clk, rst_n : clock, async active-low reset (signature -> 0)
//     clear      : synchronous clear to zero, wins over en
//     en         : advance one MISR step, injecting data
//     data       : word injected this step (already zero-extended)
//     sig        : current signature
module bist_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h8016
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_nxt;

    assign sig_nxt = SIG_W'(misr_next(SIG_MAX'(sig), SIG_MAX'(data),
                                      SIG_MAX'(POLY), SIG_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sig <= '0;
        else if (clear)
            sig <= '0;
        else if (en)
            sig <= sig_nxt;
    end

endmodule

// File: rtl/bist_response_checker.sv
// bist_response_checker
//   Compares each DUT response against its golden value, counts mismatches
//   (saturating), records the first failing pattern index and compacts the
//   observed responses into a MISR signature.
//   Optional macro RSP_XMASK_EN adds an xmask input: masked bits are ignored
//   in the compare and forced to 0 before entering the MISR.
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     start, num_pat      : session start pulse and pattern count
//     rsp_valid/rsp_ready : response handshake (ready only in RUN)
//     dut_out, exp_out    : observed and golden response
//     xmask               : don't-care bits (RSP_XMASK_EN only)
//     busy, done, pass    : session status; pass valid while done
//     fail_cnt            : mismatching patterns, saturating
//     first_fail          : first failing index, all-ones if none
//     signature           : MISR state
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting responses until num_pat transfers are seen
//   DONE  | results held until the next start
module bist_response_checker
    import bist_pkg::*;
#(
    parameter int               OUT_W = 1,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h8016,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] exp_out,
`ifdef RSP_XMASK_EN
    input  logic [OUT_W-1:0] xmask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail,
    output logic [SIG_W-1:0] signature
);

    state_t           state;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] idx_q;
    logic [OUT_W-1:0] care;
    logic             mismatch;
    logic             xfer;
    logic             last;
    logic             sess_clear;

`ifdef RSP_XMASK_EN
    assign care = ~xmask;
`else
    assign care = '1;
`endif

    assign mismatch   = |((dut_out ^ exp_out) & care);
    assign xfer       = (state == RUN) && rsp_valid && rsp_ready;
    assign last       = (idx_q == (num_q - 1'b1));
    assign sess_clear = start && (state != RUN);

    bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sess_clear),
        .en    (xfer),
        .data  (SIG_W'(dut_out & care)),
        .sig   (signature)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rsp_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '1;
            idx_q      <= '0;
            num_q      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fail_cnt   <= '0;
                        first_fail <= '1;
                        idx_q      <= '0;
                        num_q      <= num_pat;
                        if (num_pat != '0) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            rsp_ready <= 1'b1;
                            done      <= 1'b0;
                            pass      <= 1'b0;
                        end else begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            rsp_ready <= 1'b0;
                            done      <= 1'b1;
                            pass      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (mismatch) begin
                            if (fail_cnt != '1)
                                fail_cnt <= fail_cnt + 1'b1;
                            // fail_cnt never returns to zero once bumped,
                            // so zero means no earlier mismatch.
                            if (fail_cnt == '0)
                                first_fail <= idx_q;
                        end
                        idx_q <= idx_q + 1'b1;
                        if (last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            rsp_ready <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (fail_cnt == '0) && !mismatch;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_response_checker.sv
module tb_bist_response_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_pat = '0;
    logic        rsp_valid = 1'b0;
    logic        dut_out = 1'b0;
    logic        exp_out = 1'b0;
    logic        xmask = 1'b0;
    logic        rsp_ready, busy, done, pass;
    logic [15:0] fail_cnt, first_fail, signature;

    logic        start2 = 1'b0;
    logic [1:0]  num_pat2 = '0;
    logic        rsp_ready2, busy2, done2, pass2;
    logic [1:0]  fail_cnt2, first_fail2;
    logic [15:0] signature2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bist_response_checker #(
        .OUT_W(1), .SIG_W(16), .POLY(16'h8016), .CNT_W(16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_pat    (num_pat),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .dut_out    (dut_out),
        .exp_out    (exp_out),
`ifdef RSP_XMASK_EN
        .xmask      (xmask),
`endif
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_cnt   (fail_cnt),
        .first_fail (first_fail),
        .signature  (signature)
    );

    bist_response_checker #(
        .OUT_W(1), .SIG_W(16), .POLY(16'h8016), .CNT_W(2)
    ) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .num_pat    (num_pat2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready2),
        .dut_out    (dut_out),
        .exp_out    (exp_out),
`ifdef RSP_XMASK_EN
        .xmask      (xmask),
`endif
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .fail_cnt   (fail_cnt2),
        .first_fail (first_fail2),
        .signature  (signature2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start   = 1'b1;
        num_pat = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input logic d, input logic e);
        rsp_valid = 1'b1;
        dut_out   = d;
        exp_out   = e;
        tick();
        rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk("rst_ready", 32'(rsp_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_first_fail", 32'(first_fail), 32'hFFFF);
        chk("rst_sig", 32'(signature), 32'd0);
        rst_n = 1'b1;
        tick();

        // all-match session: data 0,1,1,0 -> sig 0,1,3,6
        do_start(16'd4);
        chk("match_busy", 32'(busy), 32'd1);
        chk("match_ready", 32'(rsp_ready), 32'd1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        chk("match_not_done", 32'(done), 32'd0);
        send(1'b0, 1'b0);
        chk("match_done", 32'(done), 32'd1);
        chk("match_pass", 32'(pass), 32'd1);
        chk("match_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("match_first_fail", 32'(first_fail), 32'hFFFF);
        chk("match_sig", 32'(signature), 32'h0006);

        // single fault at index 2 (back-to-back start from DONE): sig 0,1,2,4
        do_start(16'd4);
        chk("fault_done_clr", 32'(done), 32'd0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        chk("fault_done", 32'(done), 32'd1);
        chk("fault_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("fault_first_fail", 32'(first_fail), 32'd2);
        chk("fault_pass", 32'(pass), 32'd0);
        chk("fault_sig", 32'(signature), 32'h0004);

        // stalls: valid 1,0,0,1,0,0,1 over 3 patterns, data 1 -> sig 1,3,7
        do_start(16'd3);
        send(1'b1, 1'b1);
        tick();
        tick();
        chk("stall_sig_held", 32'(signature), 32'h0001);
        send(1'b1, 1'b1);
        chk("stall_not_done", 32'(done), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        tick();
        tick();
        send(1'b1, 1'b1);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_ready_low", 32'(rsp_ready), 32'd0);
        chk("stall_sig", 32'(signature), 32'h0007);
        // responses in DONE change nothing
        send(1'b1, 1'b0);
        chk("done_ignore_fail", 32'(fail_cnt), 32'd0);
        chk("done_ignore_sig", 32'(signature), 32'h0007);

        // polynomial feedback: 1 then 16 zeros -> 0x8000 then 0x8016
        do_start(16'd17);
        send(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) send(1'b0, 1'b0);
        chk("poly_sig_msb", 32'(signature), 32'h8000);
        send(1'b0, 1'b0);
        chk("poly_done", 32'(done), 32'd1);
        chk("poly_sig", 32'(signature), 32'h8016);

        // reset mid-session
        do_start(16'd5);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        chk("mid_sig_partial", 32'(signature), 32'h0003);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(rsp_ready), 32'd0);
        chk("mid_rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("mid_rst_first_fail", 32'(first_fail), 32'hFFFF);
        chk("mid_rst_sig", 32'(signature), 32'd0);
        rst_n = 1'b1;
        tick();
        do_start(16'd1);
        send(1'b1, 1'b0);
        chk("post_rst_done", 32'(done), 32'd1);
        chk("post_rst_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("post_rst_first_fail", 32'(first_fail), 32'd0);
        chk("post_rst_sig", 32'(signature), 32'h0001);

        // num_pat = 0 goes straight to DONE with pass
        do_start(16'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_pass", 32'(pass), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_fail_cnt", 32'(fail_cnt), 32'd0);

        // start during RUN is ignored
        do_start(16'd2);
        send(1'b1, 1'b1);
        do_start(16'd5);
        chk("rerun_busy", 32'(busy), 32'd1);
        chk("rerun_sig_kept", 32'(signature), 32'h0001);
        send(1'b0, 1'b1);
        chk("rerun_done", 32'(done), 32'd1);
        chk("rerun_first_fail", 32'(first_fail), 32'd1);
        chk("rerun_sig", 32'(signature), 32'h0002);

        // 2-bit counters: three mismatches fill the counter to all-ones
        start2   = 1'b1;
        num_pat2 = 2'd3;
        tick();
        start2   = 1'b0;
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        chk("cnt2_done", 32'(done2), 32'd1);
        chk("cnt2_fail_cnt", 32'(fail_cnt2), 32'd3);
        chk("cnt2_first_fail", 32'(first_fail2), 32'd0);
        chk("cnt2_pass", 32'(pass2), 32'd0);

`ifdef RSP_XMASK_EN
        // masked bit neither counts nor enters the MISR: sig 0 then 1
        do_start(16'd2);
        xmask = 1'b1;
        send(1'b1, 1'b0);
        xmask = 1'b0;
        send(1'b1, 1'b1);
        chk("xmask_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("xmask_pass", 32'(pass), 32'd1);
        chk("xmask_sig", 32'(signature), 32'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
